// File: rtl/period_meter_27_if.sv
// period_meter_27_if: groups the measured input, control and result lines of the period meter.
// Latency: none; this is wiring only.
// Backpressure: none; results are strobes that the consumer must capture.
interface period_meter_27_if #(
  parameter int CNT_WIDTH = 27
);
  logic                 sig_in;
  logic                 start;
  logic                 cont;
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 busy;
  logic                 overflow;

  // Stimulus / consumer side.
  modport master (
    output sig_in, start, cont,
    input  period, period_valid, busy, overflow
  );

  // Meter side.
  modport slave (
    input  sig_in, start, cont,
    output period, period_valid, busy, overflow
  );
endinterface

// File: rtl/period_meter_27.sv
// period_meter_27: counts clk cycles between consecutive rising edges of an asynchronous slow input.
// Latency: period_valid rises SYNC_STAGES+1 cycles after the terminating sig_in edge is sampled.
// Backpressure: none; period/overflow are held until the next result, period_valid is a 1-cycle strobe.
module period_meter_27 #(
  parameter int CNT_WIDTH   = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  period_meter_27_if.slave bus
);

  localparam int                   WU_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0]      WU_DONE = WU_W'(SYNC_STAGES + 1);
  localparam logic [WU_W-1:0]      WU_ONE  = WU_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [WU_W-1:0]        wu_cnt;
  logic                   wu_done;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   at_max;
  logic [CNT_WIDTH-1:0]   period_q;
  logic                   overflow_q;
  logic                   valid_q;
  logic                   busy_c;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign wu_done = (wu_cnt == WU_DONE);
  assign at_max  = (cnt == CNT_MAX);

  // Synchronizer chain plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d    <= s;
    end
  end

  // Warm-up: hold off starts until the synchronizer has flushed its post-reset contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wu_cnt <= '0;
    end else if (!wu_done) begin
      wu_cnt <= wu_cnt + WU_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a rise ends an interval even when the counter just hit max.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start && wu_done) state_nxt = ARM;
      end
      ARM: begin
        if (rise) state_nxt = COUNT;
      end
      COUNT: begin
        if (rise)        state_nxt = bus.cont ? COUNT : IDLE;
        else if (at_max) state_nxt = bus.cont ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers the whole armed/counting window.
  always_comb begin
    busy_c = 1'b0;
    if (state == ARM || state == COUNT) busy_c = 1'b1;
  end

  // Interval counter and result registers; the terminating edge also starts the next interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ARM: begin
          if (rise) cnt <= CNT_ONE;
        end
        COUNT: begin
          if (rise) begin
            period_q   <= cnt;
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            cnt        <= CNT_ONE;
          end else if (at_max) begin
            period_q   <= CNT_MAX;
            overflow_q <= 1'b1;
            valid_q    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = busy_c;

endmodule

// File: tb/tb_period_meter_27.sv
// tb_period_meter_27: directed scoreboard bench for period_meter_27 (27-bit and 8-bit instances).
// Latency: results are awaited with bounded cycle budgets.
// Backpressure: none.
module tb_period_meter_27;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  period_meter_27_if #(.CNT_WIDTH(27)) bus ();
  period_meter_27_if #(.CNT_WIDTH(8))  bus8 ();

  period_meter_27 #(.CNT_WIDTH(27), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  period_meter_27 #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  typedef struct packed {
    logic [26:0] per;
    logic        ov;
  } exp_t;

  exp_t q27[$];
  exp_t q8[$];

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int strb27 = 0;
  int strb8  = 0;

  // Signal generator: 0 = hold gen_hold, 1 = square wave, 2 = bit 3 of a 4-bit divider.
  int         gen_mode = 0;
  logic       gen_hold = 1'b0;
  int         pend_hi  = 8;
  int         pend_lo  = 8;
  int         gen_hi   = 8;
  int         gen_lo   = 8;
  int         ph_cnt   = 0;
  logic       gen_out  = 1'b0;
  logic [3:0] div_cnt  = 4'd0;

  assign bus.sig_in  = gen_out;
  assign bus8.sig_in = gen_out;

  // Generator; new square-wave phases take effect on a rising transition.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      div_cnt = div_cnt + 4'd1;
      if (gen_mode == 1) begin
        ph_cnt = ph_cnt + 1;
        if (ph_cnt >= (gen_out ? gen_hi : gen_lo)) begin
          gen_out = ~gen_out;
          ph_cnt  = 0;
          if (gen_out) begin
            gen_hi = pend_hi;
            gen_lo = pend_lo;
          end
        end
      end else begin
        ph_cnt = 0;
        gen_hi = pend_hi;
        gen_lo = pend_lo;
        gen_out = (gen_mode == 2) ? div_cnt[3] : gen_hold;
      end
    end
  end

  // Cycle counter.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Strobe counters.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.period_valid === 1'b1)  strb27 = strb27 + 1;
      if (bus8.period_valid === 1'b1) strb8  = strb8 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_gen(input int mode, input int hi, input int lo);
    pend_hi = hi;
    pend_lo = lo;
    @(negedge clk);
    gen_mode = mode;
  endtask

  task automatic pulse_start(input bit w8);
    @(posedge clk);
    #1;
    if (w8) bus8.start = 1'b1; else bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (w8) bus8.start = 1'b0; else bus.start = 1'b0;
  endtask

  task automatic push_exp(input bit w8, input int per, input logic ov);
    exp_t e;
    e.per = 27'(per);
    e.ov  = ov;
    if (w8) q8.push_back(e); else q27.push_back(e);
  endtask

  // Waits for the next strobe, pops the scoreboard and compares period/overflow.
  task automatic get_result(input bit w8, input int budget, output int at_cyc, output logic busy_at);
    logic        v;
    int          n;
    exp_t        e;
    logic [26:0] per_obs;
    logic        ov_obs;
    int          qs;
    n       = 0;
    at_cyc  = 0;
    busy_at = 1'b0;
    @(negedge clk);
    v = w8 ? bus8.period_valid : bus.period_valid;
    while (v !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      v = w8 ? bus8.period_valid : bus.period_valid;
    end
    chk(w8 ? "strobe_seen8" : "strobe_seen", 32'(v), 32'd1);
    if (v === 1'b1) begin
      at_cyc  = cyc;
      per_obs = w8 ? {19'd0, bus8.period} : bus.period;
      ov_obs  = w8 ? bus8.overflow : bus.overflow;
      busy_at = w8 ? bus8.busy : bus.busy;
      qs      = w8 ? q8.size() : q27.size();
      chk("sb_nonempty", 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        if (w8) e = q8.pop_front(); else e = q27.pop_front();
        chk(w8 ? "period8" : "period", 32'(per_obs), 32'(e.per));
        chk(w8 ? "overflow8" : "overflow", 32'(ov_obs), 32'(e.ov));
      end
      @(negedge clk);
      chk("strobe_width", 32'(w8 ? bus8.period_valid : bus.period_valid), 32'd0);
    end
  endtask

  initial begin
    int   c0, c1, s0, n;
    logic b, prev, found;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus8.start = 1'b0;
    bus8.cont  = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_period",   32'(bus.period),       32'd0);
    chk("rst_valid",    32'(bus.period_valid), 32'd0);
    chk("rst_busy",     32'(bus.busy),         32'd0);
    chk("rst_overflow", 32'(bus.overflow),     32'd0);

    // Start held through the warm-up window must be ignored.
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("warmup_start_ignored", 32'(bus.busy), 32'd0);

    // Single-shot, period 16.
    set_gen(1, 8, 8);
    repeat (20) @(negedge clk);
    push_exp(0, 16, 1'b0);
    pulse_start(0);
    @(negedge clk);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    get_result(0, 100, c0, b);
    chk("busy_at_single_strobe", 32'(b), 32'd0);
    s0 = strb27;
    repeat (40) @(negedge clk);
    chk("single_one_strobe", 32'(strb27 - s0), 32'd0);
    chk("busy_after_single", 32'(bus.busy), 32'd0);

    // Continuous, period 10, then 12; start pulses mid-run are ignored.
    pend_hi = 5;
    pend_lo = 5;
    repeat (40) @(negedge clk);
    bus.cont = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(0, 10, 1'b0);
    pulse_start(0);
    get_result(0, 100, c0, b);
    repeat (2) @(negedge clk);
    pulse_start(0);
    get_result(0, 40, c1, b);
    chk("cont_interval_a", 32'(c1 - c0), 32'd10);
    c0 = c1;
    get_result(0, 40, c1, b);
    chk("cont_interval_b", 32'(c1 - c0), 32'd10);
    c0 = c1;
    pend_hi = 6;
    pend_lo = 6;
    push_exp(0, 10, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(0, 12, 1'b0);
    get_result(0, 40, c1, b);
    chk("switch_last10", 32'(c1 - c0), 32'd10);
    c0 = c1;
    for (int i = 0; i < 3; i++) begin
      get_result(0, 40, c1, b);
      chk("cont_interval_12", 32'(c1 - c0), 32'd12);
      c0 = c1;
    end
    bus.cont = 1'b0;
    push_exp(0, 12, 1'b0);
    get_result(0, 40, c1, b);
    chk("cont_clear_interval", 32'(c1 - c0), 32'd12);
    chk("busy_after_cont_clear", 32'(b), 32'd0);
    s0 = strb27;
    repeat (30) @(negedge clk);
    chk("cont_clear_no_more", 32'(strb27 - s0), 32'd0);

    // Reset in the middle of COUNT.
    pend_hi = 8;
    pend_lo = 8;
    repeat (40) @(negedge clk);
    pulse_start(0);
    n     = 0;
    found = 1'b0;
    prev  = gen_out;
    while (!found && n < 60) begin
      @(negedge clk);
      if (gen_out && !prev) found = 1'b1;
      prev = gen_out;
      n++;
    end
    chk("gen_rise_seen", 32'(found), 32'd1);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_period",   32'(bus.period),       32'd0);
    chk("midrst_valid",    32'(bus.period_valid), 32'd0);
    chk("midrst_busy",     32'(bus.busy),         32'd0);
    chk("midrst_overflow", 32'(bus.overflow),     32'd0);
    s0 = strb27;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_strobe", 32'(strb27 - s0), 32'd0);
    push_exp(0, 16, 1'b0);
    pulse_start(0);
    get_result(0, 100, c0, b);

    // Integration with a 4-bit divider.
    set_gen(2, 8, 8);
    repeat (20) @(negedge clk);
    bus.cont = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(0, 16, 1'b0);
    pulse_start(0);
    for (int i = 0; i < 4; i++) get_result(0, 60, c0, b);
    bus.cont = 1'b0;
    push_exp(0, 16, 1'b0);
    get_result(0, 40, c0, b);
    chk("busy_after_div", 32'(b), 32'd0);

    // 8-bit: interval exactly at max, rise wins over saturation.
    set_gen(1, 100, 155);
    repeat (5) @(negedge clk);
    push_exp(1, 255, 1'b0);
    pulse_start(1);
    get_result(1, 700, c0, b);

    // 8-bit: overflow, then a valid 20-cycle measurement clears it.
    set_gen(0, 10, 10);
    gen_hold = 1'b0;
    repeat (5) @(negedge clk);
    bus8.cont = 1'b1;
    pulse_start(1);
    repeat (5) @(negedge clk);
    gen_hold = 1'b1;
    repeat (6) @(negedge clk);
    gen_hold = 1'b0;
    push_exp(1, 255, 1'b1);
    get_result(1, 400, c0, b);
    chk("busy_after_ovf_cont", 32'(bus8.busy), 32'd1);
    bus8.cont = 1'b0;
    set_gen(1, 10, 10);
    push_exp(1, 20, 1'b0);
    get_result(1, 200, c0, b);
    chk("busy8_after_single", 32'(b), 32'd0);
    chk("sb_drained", 32'(q27.size() + q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter_27.md
# period_meter_27

Measures the period of a slow, asynchronous square wave in units of the system clock. Its typical input is the divided clock produced by the frequency dividers on the lab board. It synchronizes the input, detects rising edges, and counts system-clock cycles between two consecutive rising edges. Each result is reported as a registered period value with a one-cycle valid strobe. It is the measuring end of the divider chain and is used to check divider outputs on hardware and in simulation.

## Interface
- CNT_WIDTH, 27: width of the period counter and the result.
- SYNC_STAGES, 2: number of synchronizer flops on sig_in (≥2).
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- sig_in  input  1  slow signal to measure; asynchronous to clk.
- start  input  1  one-cycle request to begin a measurement; sampled only in IDLE.
- cont  input  1  level; 1 = continuous measurement, 0 = single-shot.
- period  output  CNT_WIDTH  last measured period in clk cycles; held until the next result.
- period_valid  output  1  one-cycle strobe; period and overflow are updated in the same cycle.
- busy  output  1  high in ARM and COUNT.
- overflow  output  1  1 when the held result saturated; updated together with period.

## Operation
- **Synchronizer:** SYNC_STAGES flops, all reset to 0. The output is s. A history flop s_d loads s every cycle and resets to 0.
- **Edge detect:** rise = s & ~s_d (combinational). It is used only in ARM and COUNT.
- **Warm-up:** a small counter runs for SYNC_STAGES+1 cycles after rst_n deasserts. A start during warm-up is ignored.
- **FSM states:** IDLE, ARM, COUNT. Reset state is IDLE.
- **IDLE:**
  - start=1 with warm-up done → ARM.
  - All other inputs are ignored.
- **ARM:**
  - rise → COUNT, cnt<=1.
  - No rise: remain in ARM indefinitely.
- **COUNT, no rise, cnt < max (all ones):** cnt<=cnt+1.
- **COUNT, rise:**
  - period<=cnt, overflow<=0, period_valid<=1.
  - cont=1 → stay in COUNT, cnt<=1. The same edge starts the next interval, so there are no gaps.
  - cont=0 → IDLE.
- **COUNT, no rise, cnt == max:**
  - period<=max, overflow<=1, period_valid<=1.
  - cont=1 → ARM; cont=0 → IDLE.
- **Simultaneous rise and cnt==max:** the rise wins, and the result is max with overflow=0.
- **start while busy:** ignored; it does not restart the measurement.
- **cont:** sampled at every result. Clearing it mid-measurement ends operation after the current result.
- **Arithmetic:** cnt is CNT_WIDTH bits unsigned and never wraps; it saturates through the overflow path.
- **Result meaning:** for a sig_in period of N clk cycles with N < 2^CNT_WIDTH−1, period = N exactly. Synchronizer delay cancels because both edges see the same latency.

## Timing
- **Reset values:** period=0, period_valid=0, busy=0, overflow=0, cnt=0, state=IDLE, synchronizer and warm-up cleared. Reset takes effect immediately (asynchronous). Reset mid-measurement discards the measurement with no valid strobe.
- **busy:** goes high the cycle after start is accepted. It goes low in the same cycle period_valid rises for a single-shot result.
- **Edge latency:** a sig_in rising transition sampled at posedge k is seen as rise in cycle k+SYNC_STAGES.
- **Result latency:** period_valid is asserted in the cycle after the terminating rise is detected, i.e. SYNC_STAGES+1 cycles after the sig_in transition is sampled.
- **Strobe width:** period_valid is exactly one cycle wide and never back-to-back, since the minimum interval is 2 cycles.
- **Input requirement:** sig_in high and low phases must each be ≥ SYNC_STAGES+1 clk cycles. Shorter pulses may be missed; this is not checked.

## Test plan
- **Single-shot:** sig_in square wave of period 16 (8 high/8 low), start pulse, cont=0 → exactly one period_valid with period=16, overflow=0. busy is high from the cycle after start until the strobe, then stays low.
- **Continuous:** cont=1, sig_in period 10, switched to period 12 mid-run → strobes every 10 cycles with period=10. After the switch, the first full interval and all following report 12, and there are no missed intervals.
- **Overflow:** CNT_WIDTH=8, arm on one rising edge, then hold sig_in low → strobe with period=8'hFF, overflow=1. A following valid measurement of period 20 clears overflow to 0.
- **Ignored start:**
  - start held in the first SYNC_STAGES+1 cycles after reset → busy stays 0.
  - start pulses during COUNT → result unchanged.
- **Reset mid-COUNT:** assert rst_n=0 mid-COUNT → all outputs 0 immediately and no strobe. After release and warm-up, a new start measures period 16 correctly.
- **Integration:** sig_in driven by bit 3 of a free-running 4-bit divider counter on the same clk → period=16 on every continuous strobe.
